branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Responder side of the IF-stage predictor interface.
- Receives the fetch PC on if_to_bp_bus and returns the same-cycle prediction on bp_to_if_bus. That prediction is a direction from a 2-bit-counter PHT plus a target from a direct-mapped BTB.
- Trained by resolved branches from EX through a one-cycle registered update path with forwarding.
- Also keeps lookup and mispredict performance counters.

Parameters:
- PHT_IDX_W, 8, PHT index bits (256 entries), index = pc[PHT_IDX_W+1:2]
- BTB_IDX_W, 5, BTB index bits (32 entries), index = pc[BTB_IDX_W+1:2]
- BTB_TAG_W, 25, tag bits, tag = pc[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2]

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- if_to_bp_bus  in  33  {bp_en[32], bp_pc[31:0]}
- bp_to_if_bus  out  37  {predict_valid[36], predict_taken[35], predict_state[34:33], btb_hit[32], predict_target[31:0]}
- ex_to_bp_bus  in  67  {upd_valid[66], upd_pc[65:34], upd_taken[33], upd_target[32:1], upd_mispredict[0]}
- perf_lookup_cnt  out  32  count of cycles with bp_en=1
- perf_mispred_cnt  out  32  count of accepted updates with upd_mispredict=1

Behaviour:
- Reset (async, resetn=0), values that must hold:
  - every PHT entry = 2'b01 (weakly not-taken)
  - every BTB valid = 0; tags and targets = 0
  - pending-update register invalid
  - predict_valid register = 0
  - both perf counters = 0
- predict_valid: register, 0 during reset, becomes 1 on the first rising clk after resetn deasserts, then stays 1.
- predict_valid must not depend on bp_en. IF derives bp_en from bp_taken, so any dependency forms a combinational loop.
- Lookup is purely combinational on bp_pc and current state, with zero latency:
  - predict_state = effective PHT[pidx(bp_pc)]
  - predict_taken = predict_state[1]
  - btb_hit = effective BTB_valid[bidx] && BTB_tag[bidx] == tag(bp_pc)
  - predict_target = effective BTB_target[bidx], or 0 when btb_hit=0
- IF takes the redirect only when predict_valid && predict_taken && btb_hit; this block does not gate that.
- Update stage 1, at the clk edge with upd_valid=1:
  - capture pending = {pidx, bidx, tag, taken, target, new_state}
  - new_state = saturating counter of base_state, +1 if taken else -1, clamped to 00..11
  - base_state = pending.new_state when pending is valid and pending.pidx equals this pidx (back-to-back same index); otherwise PHT[pidx]
  - pending.valid <= upd_valid every cycle
- Update stage 2, the edge after capture, when pending valid:
  - PHT[pending.pidx] <= new_state
  - if taken: BTB[pending.bidx] <= {1, tag, target}
  - not-taken updates leave the BTB unchanged
- Forwarding: while pending is valid, lookups whose pidx or bidx match see the pending PHT state / BTB entry. The BTB forward applies only when pending.taken=1. Net effect: a trained result is visible to lookups in the cycle immediately after the upd_valid edge.
- Aliasing: different PCs sharing an index share PHT state. A BTB tag mismatch gives btb_hit=0. A taken update overwrites the BTB entry regardless of the old tag.
- perf counters:
  - perf_lookup_cnt increments when bp_en=1
  - perf_mispred_cnt increments when upd_valid && upd_mispredict
  - both are 32-bit and wrap 0xFFFFFFFF -> 0
- Reset mid-operation drops any pending update; tables return to reset values.
- Lookup and update of the same entry in the same cycle: the lookup returns the pre-capture effective value (pending or table), never the newly captured upd_* value.

Test Plan:
- Reset then release:
  - bp_to_if_bus must show predict_valid=0 while resetn=0, predict_valid=1 one edge after release
  - for bp_pc=0x1c000000: state=01, taken=0, btb_hit=0, target=0
- Single taken update pc=0x1c000010, target=0x1c000100:
  - next cycle, lookup 0x1c000010 -> state=10, taken=1, btb_hit=1, target=0x1c000100 (via forwarding)
  - two cycles later, same result from the table
- Four back-to-back taken updates to 0x1c000010 -> state saturates at 11. Then three not-taken updates -> 10, 01, 00; a fourth stays 00. The BTB entry remains valid with target 0x1c000100.
- Alias test: train 0x1c000010 taken, then look up 0x1c000090 (same bidx, different tag) -> btb_hit=0, target=0, and predict_state shows the shared PHT entry only if the pidx matches.
- Counters:
  - bp_en=1 for 5 cycles -> perf_lookup_cnt=5
  - 3 updates with upd_mispredict=1 and 2 with 0 -> perf_mispred_cnt=3
  - force perf_lookup_cnt to 0xFFFFFFFF, one lookup -> 0
- Assert resetn low the same cycle as upd_valid=1 -> after release, PHT entry=01 and BTB invalid for that pc.

Source files
------------

// File: rtl/branch_predictor.sv
// IF-stage branch predictor: 2-bit counter PHT plus direct-mapped BTB, same-cycle lookup,
// one-cycle registered training path with forwarding, and lookup/mispredict perf counters.
module branch_predictor #(
  parameter int unsigned PHT_IDX_W = 8,
  parameter int unsigned BTB_IDX_W = 5,
  parameter int unsigned BTB_TAG_W = 25
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [32:0] if_to_bp_bus,
  output logic [36:0] bp_to_if_bus,
  input  logic [66:0] ex_to_bp_bus,
  output logic [31:0] perf_lookup_cnt,
  output logic [31:0] perf_mispred_cnt
);

  localparam int PhtDepth = 1 << PHT_IDX_W;
  localparam int BtbDepth = 1 << BTB_IDX_W;

  // Bus fields
  logic        bp_en;
  logic [31:0] bp_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;

  assign {bp_en, bp_pc} = if_to_bp_bus;
  assign upd_valid      = ex_to_bp_bus[66];
  assign upd_pc         = ex_to_bp_bus[65:34];
  assign upd_taken      = ex_to_bp_bus[33];
  assign upd_target     = ex_to_bp_bus[32:1];
  assign upd_mispredict = ex_to_bp_bus[0];

  // Instructions are word aligned, so the low PC bits carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp_pc[1:0], upd_pc[1:0]};

  logic [PHT_IDX_W-1:0] lk_pidx, up_pidx;
  logic [BTB_IDX_W-1:0] lk_bidx, up_bidx;
  logic [BTB_TAG_W-1:0] lk_tag, up_tag;

  assign lk_pidx = bp_pc[PHT_IDX_W+1:2];
  assign lk_bidx = bp_pc[BTB_IDX_W+1:2];
  assign lk_tag  = bp_pc[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];
  assign up_pidx = upd_pc[PHT_IDX_W+1:2];
  assign up_bidx = upd_pc[BTB_IDX_W+1:2];
  assign up_tag  = upd_pc[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];

  // Tables
  logic [PhtDepth-1:0][1:0]           pht_q;
  logic [BtbDepth-1:0]                btb_valid_q;
  logic [BtbDepth-1:0][BTB_TAG_W-1:0] btb_tag_q;
  logic [BtbDepth-1:0][31:0]          btb_target_q;

  // Pending update (stage 1 -> stage 2)
  logic                 pend_valid_q;
  logic [PHT_IDX_W-1:0] pend_pidx_q;
  logic [BTB_IDX_W-1:0] pend_bidx_q;
  logic [BTB_TAG_W-1:0] pend_tag_q;
  logic                 pend_taken_q;
  logic [31:0]          pend_target_q;
  logic [1:0]           pend_state_q;

  logic        predict_valid_q;
  logic [31:0] lookup_cnt_q, lookup_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  // Lookup: effective state is the pending entry when it targets the same index.
  logic [1:0]           lk_state;
  logic                 lk_btb_valid;
  logic [BTB_TAG_W-1:0] lk_btb_tag;
  logic [31:0]          lk_btb_target;
  logic                 btb_hit;
  logic [31:0]          predict_target;

  always_comb begin
    lk_state = pht_q[lk_pidx];
    if (pend_valid_q && (pend_pidx_q == lk_pidx)) begin
      lk_state = pend_state_q;
    end
    lk_btb_valid  = btb_valid_q[lk_bidx];
    lk_btb_tag    = btb_tag_q[lk_bidx];
    lk_btb_target = btb_target_q[lk_bidx];
    if (pend_valid_q && pend_taken_q && (pend_bidx_q == lk_bidx)) begin
      lk_btb_valid  = 1'b1;
      lk_btb_tag    = pend_tag_q;
      lk_btb_target = pend_target_q;
    end
  end

  assign btb_hit        = lk_btb_valid && (lk_btb_tag == lk_tag);
  assign predict_target = btb_hit ? lk_btb_target : 32'h0;

  // predict_valid is purely registered so IF's bp_en feedback cannot form a loop.
  assign bp_to_if_bus = {predict_valid_q, lk_state[1], lk_state, btb_hit, predict_target};

  // Stage 1: saturating counter from the effective (possibly pending) base state.
  logic [1:0] base_state;
  logic [1:0] new_state;

  always_comb begin
    base_state = pht_q[up_pidx];
    if (pend_valid_q && (pend_pidx_q == up_pidx)) begin
      base_state = pend_state_q;
    end
    new_state = base_state;
    if (upd_taken) begin
      if (base_state != 2'b11) new_state = base_state + 2'd1;
    end else begin
      if (base_state != 2'b00) new_state = base_state - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_valid_q  <= 1'b0;
      pend_pidx_q   <= '0;
      pend_bidx_q   <= '0;
      pend_tag_q    <= '0;
      pend_taken_q  <= 1'b0;
      pend_target_q <= '0;
      pend_state_q  <= 2'b01;
    end else begin
      pend_valid_q <= upd_valid;
      if (upd_valid) begin
        pend_pidx_q   <= up_pidx;
        pend_bidx_q   <= up_bidx;
        pend_tag_q    <= up_tag;
        pend_taken_q  <= upd_taken;
        pend_target_q <= upd_target;
        pend_state_q  <= new_state;
      end
    end
  end

  // Stage 2: commit the pending entry into the tables.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pht_q <= {PhtDepth{2'b01}};
    end else if (pend_valid_q) begin
      pht_q[pend_pidx_q] <= pend_state_q;
    end
  end

  // Not-taken updates leave the BTB alone; taken ones overwrite regardless of old tag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btb_valid_q  <= '0;
      btb_tag_q    <= '0;
      btb_target_q <= '0;
    end else if (pend_valid_q && pend_taken_q) begin
      btb_valid_q[pend_bidx_q]  <= 1'b1;
      btb_tag_q[pend_bidx_q]    <= pend_tag_q;
      btb_target_q[pend_bidx_q] <= pend_target_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      predict_valid_q <= 1'b0;
    end else begin
      predict_valid_q <= 1'b1;
    end
  end

  // Performance counters, free-running with natural 32-bit wrap.
  always_comb begin
    lookup_cnt_d  = lookup_cnt_q + 32'd1;
    mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lookup_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (bp_en) lookup_cnt_q <= lookup_cnt_d;
      if (upd_valid && upd_mispredict) mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign perf_lookup_cnt  = lookup_cnt_q;
  assign perf_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed steps plus random traffic checked against an
// architectural model where every resolved branch updates the tables at its own edge.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        resetn;
  logic [32:0] if_to_bp_bus;
  logic [36:0] bp_to_if_bus;
  logic [66:0] ex_to_bp_bus;
  logic [31:0] perf_lookup_cnt;
  logic [31:0] perf_mispred_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Architectural model
  logic [1:0]  m_pht  [256];
  bit          m_bv   [32];
  logic [24:0] m_btag [32];
  logic [31:0] m_btgt [32];
  logic [31:0] m_lk;
  logic [31:0] m_mp;
  bit          m_pv;

  localparam logic [31:0] PcA  = 32'h1c00_0010;
  localparam logic [31:0] TgtA = 32'h1c00_0100;
  localparam logic [31:0] PcB  = 32'h1c00_0040;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk              (clk),
    .resetn           (resetn),
    .if_to_bp_bus     (if_to_bp_bus),
    .bp_to_if_bus     (bp_to_if_bus),
    .ex_to_bp_bus     (ex_to_bp_bus),
    .perf_lookup_cnt  (perf_lookup_cnt),
    .perf_mispred_cnt (perf_mispred_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [36:0] m_bus(input logic [31:0] pc);
    logic [1:0] s;
    bit         h;
    s = m_pht[pc[9:2]];
    h = m_bv[pc[6:2]] && (m_btag[pc[6:2]] == pc[31:7]);
    return {m_pv, s[1], s, h, h ? m_btgt[pc[6:2]] : 32'h0};
  endfunction

  task automatic m_reset();
    foreach (m_pht[i]) m_pht[i] = 2'b01;
    foreach (m_bv[i]) begin
      m_bv[i]   = 1'b0;
      m_btag[i] = '0;
      m_btgt[i] = '0;
    end
    m_lk = '0;
    m_mp = '0;
    m_pv = 1'b0;
  endtask

  task automatic m_clock();
    logic [31:0] upc;
    int          s;
    if (if_to_bp_bus[32]) m_lk++;
    if (ex_to_bp_bus[66]) begin
      upc = ex_to_bp_bus[65:34];
      if (ex_to_bp_bus[0]) m_mp++;
      s = int'(m_pht[upc[9:2]]);
      s = ex_to_bp_bus[33] ? ((s < 3) ? s + 1 : 3) : ((s > 0) ? s - 1 : 0);
      m_pht[upc[9:2]] = 2'(s);
      if (ex_to_bp_bus[33]) begin
        m_bv[upc[6:2]]   = 1'b1;
        m_btag[upc[6:2]] = upc[31:7];
        m_btgt[upc[6:2]] = ex_to_bp_bus[32:1];
      end
    end
    m_pv = 1'b1;
  endtask

  task automatic step(input bit en, input logic [31:0] pc, input bit uv, input logic [31:0] upc,
                      input bit ut, input logic [31:0] utgt, input bit um);
    @(negedge clk);
    if_to_bp_bus = {en, pc};
    ex_to_bp_bus = {uv, upc, ut, utgt, um};
    #1 chk("lookup", 64'(bp_to_if_bus), 64'(m_bus(pc)));
    @(posedge clk);
    m_clock();
    #1;
    chk("lookup_cnt", 64'(perf_lookup_cnt), 64'(m_lk));
    chk("mispred_cnt", 64'(perf_mispred_cnt), 64'(m_mp));
  endtask

  task automatic look(input logic [31:0] pc);
    @(negedge clk);
    if_to_bp_bus = {1'b0, pc};
    ex_to_bp_bus = '0;
    #1 chk("look_model", 64'(bp_to_if_bus), 64'(m_bus(pc)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn       = 1'b0;
    if_to_bp_bus = '0;
    ex_to_bp_bus = '0;
    #1 m_reset();
    chk("rst_pv", 64'(bp_to_if_bus[36]), 64'(1'b0));
    chk("rst_cnt", 64'({perf_lookup_cnt, perf_mispred_cnt}), 64'h0);
    @(negedge clk);
    resetn = 1'b1;
    #1 chk("pv_pre_edge", 64'(bp_to_if_bus[36]), 64'(1'b0));
    @(posedge clk);
    m_pv = 1'b1;
    #1 chk("pv_post_edge", 64'(bp_to_if_bus[36]), 64'(1'b1));
  endtask

  function automatic logic [31:0] rpc();
    return 32'h1c00_0000 | (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 7)
         | (32'($urandom_range(0, 1)) << 10);
  endfunction

  initial begin
    logic [1:0] nt_exp [4];
    bit         mp_pat [5];
    nt_exp = '{2'b10, 2'b01, 2'b00, 2'b00};
    mp_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    resetn       = 1'b0;
    if_to_bp_bus = '0;
    ex_to_bp_bus = '0;
    m_reset();

    do_reset();
    look(32'h1c00_0000);
    chk("rst_lookup", 64'(bp_to_if_bus[35:0]), 64'({1'b0, 2'b01, 1'b0, 32'h0}));

    // Single taken update: forwarded next cycle, then from the table
    step(1'b0, 32'h0, 1'b1, PcA, 1'b1, TgtA, 1'b0);
    look(PcA);
    chk("taken_fwd", 64'(bp_to_if_bus[35:0]), 64'({1'b1, 2'b10, 1'b1, TgtA}));
    look(PcA);
    look(PcA);
    chk("taken_table", 64'(bp_to_if_bus[35:0]), 64'({1'b1, 2'b10, 1'b1, TgtA}));

    // Saturation both ways with back-to-back updates
    repeat (4) step(1'b0, 32'h0, 1'b1, PcA, 1'b1, TgtA, 1'b0);
    look(PcA);
    chk("sat_hi", 64'(bp_to_if_bus[35:0]), 64'({1'b1, 2'b11, 1'b1, TgtA}));
    for (int i = 0; i < 4; i++) begin
      step(1'b1, PcA, 1'b1, PcA, 1'b0, 32'h0, 1'b0);
      chk("sat_lo", 64'(bp_to_if_bus[34:32]), 64'({nt_exp[i], 1'b1}));
      chk("sat_lo_tgt", 64'(bp_to_if_bus[31:0]), 64'(TgtA));
    end

    // Aliasing: 0x..90 shares bidx only, 0x..410 shares both pidx and bidx
    step(1'b0, 32'h0, 1'b1, PcA, 1'b1, TgtA, 1'b0);
    step(1'b0, 32'h0, 1'b1, PcA, 1'b1, TgtA, 1'b0);
    look(32'h1c00_0090);
    chk("alias_tag", 64'(bp_to_if_bus[35:0]), 64'({1'b0, 2'b01, 1'b0, 32'h0}));
    look(32'h1c00_0410);
    chk("alias_pht", 64'(bp_to_if_bus[35:0]), 64'({1'b1, 2'b10, 1'b0, 32'h0}));
    step(1'b0, 32'h0, 1'b1, 32'h1c00_0090, 1'b1, 32'h1c00_0200, 1'b0);
    look(PcA);
    chk("btb_overwrite", 64'(bp_to_if_bus[35:0]), 64'({1'b1, 2'b10, 1'b0, 32'h0}));
    look(32'h1c00_0090);
    chk("btb_new", 64'(bp_to_if_bus[35:0]), 64'({1'b1, 2'b10, 1'b1, 32'h1c00_0200}));

    // Counters from a clean reset
    do_reset();
    repeat (5) step(1'b1, 32'h1c00_0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("lookup5", 64'(perf_lookup_cnt), 64'd5);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h0, 1'b1, 32'h1c00_0020 + 32'(i * 4), 1'(i % 2), 32'h1c00_1000, mp_pat[i]);
    end
    chk("mispred3", 64'(perf_mispred_cnt), 64'd3);

    // Wrap of the lookup counter at its maximum value
    @(negedge clk);
    if_to_bp_bus = {1'b1, 32'h1c00_0000};
    ex_to_bp_bus = '0;
    force dut.lookup_cnt_q = 32'hFFFF_FFFF;
    #1;
    chk("wrap_max", 64'(perf_lookup_cnt), 64'h0000_0000_FFFF_FFFF);
    chk("wrap_next", 64'(dut.lookup_cnt_d), 64'h0);
    @(posedge clk);
    #1 release dut.lookup_cnt_q;

    // Reset right after capture drops the pending update
    do_reset();
    step(1'b0, 32'h0, 1'b1, PcB, 1'b1, 32'h1c00_0300, 1'b1);
    resetn = 1'b0;
    do_reset();
    look(PcB);
    chk("rst_drop", 64'(bp_to_if_bus[35:0]), 64'({1'b0, 2'b01, 1'b0, 32'h0}));

    // Reset asserted in the same cycle as upd_valid
    @(negedge clk);
    resetn       = 1'b0;
    ex_to_bp_bus = {1'b1, PcB, 1'b1, 32'h1c00_0300, 1'b1};
    @(posedge clk);
    do_reset();
    look(PcB);
    chk("rst_same", 64'(bp_to_if_bus[35:0]), 64'({1'b0, 2'b01, 1'b0, 32'h0}));
    chk("rst_same_mp", 64'(perf_mispred_cnt), 64'h0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), rpc(), 1'($urandom_range(0, 1)), rpc(),
           1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
